// File: rtl/sar_adc_pkg.sv
// Shared types and width helpers for the SAR ADC controller.
package sar_adc_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SAMPLE   = 2'd1,
    TRIAL    = 2'd2,
    COMPLETE = 2'd3
  } state_t;

  // Bits needed to index `count` items; never less than one.
  function automatic int unsigned width_of(input int unsigned count);
    return (count <= 1) ? 1 : $clog2(count);
  endfunction

endpackage

// File: rtl/sar_adc_ctrl_if.sv
// Result bus: converted code and channel behind a valid/ready handshake.
interface sar_adc_ctrl_if #(
  parameter int unsigned N    = 8,
  parameter int unsigned CH_W = 2
);

  logic [N-1:0]    result;
  logic [CH_W-1:0] result_ch;
  logic            result_valid;
  logic            result_ready;
  logic            overrun;

  modport master (
    output result, result_ch, result_valid, overrun,
    input  result_ready
  );

  modport slave (
    input  result, result_ch, result_valid, overrun,
    output result_ready
  );

endinterface

// File: rtl/sar_result_buf.sv
// Single-entry result holding register with valid/ready and sticky overrun.
module sar_result_buf #(
  parameter int unsigned N    = 8,
  parameter int unsigned CH_W = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [N-1:0]    load_code,
  input  logic [CH_W-1:0] load_ch,
  sar_adc_ctrl_if.master  res
);

  logic take;

  assign take = res.result_valid && res.result_ready;

  // A new load always wins over a same-cycle handshake; overwriting an untaken result is an overrun.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res.result       <= '0;
      res.result_ch    <= '0;
      res.result_valid <= 1'b0;
      res.overrun      <= 1'b0;
    end else begin
      if (load) begin
        res.result       <= load_code;
        res.result_ch    <= load_ch;
        res.result_valid <= 1'b1;
      end else if (take) begin
        res.result_valid <= 1'b0;
      end

      if (load && res.result_valid && !res.result_ready) begin
        res.overrun <= 1'b1;
      end else if (take) begin
        res.overrun <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/sar_adc_ctrl.sv
// Multi-channel successive-approximation ADC controller, single-shot or auto-scan.
module sar_adc_ctrl
  import sar_adc_pkg::*;
#(
  parameter  int unsigned N             = 8,
  parameter  int unsigned CHANNELS      = 4,
  parameter  int unsigned SETTLE_CYCLES = 2,
  localparam int unsigned CH_W          = width_of(CHANNELS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [CH_W-1:0] ch_sel,
  input  logic            scan_en,
  input  logic            comp_in,
  output logic [CH_W-1:0] mux_sel,
  output logic [N-1:0]    dac_code,
  output logic            busy,
  sar_adc_ctrl_if.master  res
);

  localparam int unsigned CNT_W = width_of(SETTLE_CYCLES + 1);
  localparam int unsigned BIT_W = width_of(N);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [BIT_W-1:0] BIT_MSB  = BIT_W'(N - 1);
  localparam logic [CH_W:0]    CH_LIMIT = (CH_W + 1)'(CHANNELS);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CHANNELS - 1);

  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  cnt;
  logic [BIT_W-1:0]  bit_idx;
  logic              phase_end;
  logic              accept;
  logic              enter_trial;
  logic              decide;
  logic              complete;
  logic [N-1:0]      trial_mask;
  logic [N-1:0]      sar_decided;

  assign phase_end = (cnt == CNT_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (start) state_next = SAMPLE;
      SAMPLE:   if (phase_end) state_next = TRIAL;
      TRIAL:    if (phase_end && (bit_idx == '0)) state_next = COMPLETE;
      COMPLETE: state_next = scan_en ? SAMPLE : IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Control strobes decoded from the current state.
  always_comb begin
    accept      = 1'b0;
    enter_trial = 1'b0;
    decide      = 1'b0;
    complete    = 1'b0;
    case (state)
      IDLE:     accept      = start;
      SAMPLE:   enter_trial = phase_end;
      TRIAL:    decide      = phase_end;
      COMPLETE: complete    = 1'b1;
      default:  ;
    endcase
  end

  // Keep or drop the current trial bit, then raise the next one (if any) on the DAC.
  always_comb begin
    trial_mask  = N'(1) << bit_idx;
    sar_decided = comp_in ? dac_code : (dac_code & ~trial_mask);
    if (bit_idx != '0) begin
      sar_decided = sar_decided | (trial_mask >> 1);
    end
  end

  // Datapath: settle counter, bit index, SAR/DAC register, mux select and busy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt      <= '0;
      bit_idx  <= '0;
      dac_code <= '0;
      mux_sel  <= '0;
      busy     <= 1'b0;
    end else begin
      if ((state == SAMPLE) || (state == TRIAL)) begin
        cnt <= phase_end ? '0 : cnt + CNT_W'(1);
      end else begin
        cnt <= '0;
      end

      if (accept) begin
        mux_sel <= ({1'b0, ch_sel} >= CH_LIMIT) ? '0 : ch_sel;
        busy    <= 1'b1;
      end

      if (enter_trial) begin
        dac_code <= N'(1) << BIT_MSB;
        bit_idx  <= BIT_MSB;
      end

      if (decide) begin
        dac_code <= sar_decided;
        if (bit_idx != '0) begin
          bit_idx <= bit_idx - BIT_W'(1);
        end
      end

      if (complete) begin
        dac_code <= '0;
        if (scan_en) begin
          mux_sel <= (mux_sel == CH_LAST) ? '0 : mux_sel + CH_W'(1);
        end else begin
          busy <= 1'b0;
        end
      end
    end
  end

  // Output holding buffer; the final SAR value is still on dac_code during COMPLETE.
  sar_result_buf #(
    .N    (N),
    .CH_W (CH_W)
  ) u_result_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (complete),
    .load_code (dac_code),
    .load_ch   (mux_sel),
    .res       (res)
  );

endmodule
